// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin arbiter muxing NUM_REQ valid/ready
// requesters onto one registered valid/ready output stage.
//
// Ports:
//   sys_clk, rst          clock, synchronous active-high reset
//   s_valid/s_data/s_ready  per-requester upstream channels
//   m_valid/m_data/m_ready  downstream channel (registered)
//   m_src                 requester index of the beat in m_data
//   grant                 registered one-hot grant, zero when idle
//
// Build option: HS_ARB_BURST_LOCK_EN lets a requester keep the
// grant for up to BURST_LEN beats; otherwise it rotates per beat.

module hs_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         s_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  s_data,
  output logic [NUM_REQ-1:0]         s_ready,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(NUM_REQ)-1:0] m_src,
  input  logic                       m_ready,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN+1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IW-1:0]        last_q;
  logic [IW-1:0]        last_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 m_valid_d;
  logic [DATA_W-1:0]    m_data_d;
  logic [IW-1:0]        m_src_d;

  logic                 out_free;
  logic                 beat;
  logic                 withdraw;
  logic                 rel_cond;
  logic                 rel;
  logic                 pick_ok;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        cand;

  logic [DATA_W-1:0]    s_data_a [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign s_data_a[k] = s_data[k*DATA_W +: DATA_W];
  end

  // While granted, last_q is the granted index, so it serves both
  // as the round-robin pointer and as g.
  assign out_free = ~m_valid | m_ready;
  assign s_ready  = rst ? '0 : (grant & {NUM_REQ{out_free}});

  assign beat     = (state_q == GRANT) & s_valid[last_q] & out_free;
  assign withdraw = (state_q == GRANT) & ~s_valid[last_q];

`ifdef HS_ARB_BURST_LOCK_EN
  assign rel_cond = (cnt_q == CW'(BURST_LEN-1));
`else
  assign rel_cond = 1'b1;
`endif

  assign rel = (beat & rel_cond) | withdraw;

  // Search starts just past last_q, so the current holder
  // ends up with the lowest priority.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!pick_ok && s_valid[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = GRANT;
          last_d  = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          cnt_d = '0;
          if (pick_ok) begin
            last_d  = pick_idx;
            grant_d = NUM_REQ'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (beat && cnt_q != CW'(BURST_LEN)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    m_valid_d = m_valid;
    m_data_d  = m_data;
    m_src_d   = m_src;
    if (beat) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_a[last_q];
      m_src_d   = last_q;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ-1);
      grant   <= '0;
      cnt_q   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant   <= grant_d;
      cnt_q   <= cnt_d;
      m_valid <= m_valid_d;
      m_data  <= m_data_d;
      m_src   <= m_src_d;
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter with a requester model and an
// in-order scoreboard of expected (src, data) beats.

module tb_hs_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int BL = 2;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic [N-1:0]      s_valid;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_src;
  logic              m_ready;
  logic [N-1:0]      grant;

  int total = 0;
  int bad   = 0;
  int rem[N];
  int seq[N];
  int exp_seq[N];
  int sb[$];
  logic [N-1:0] hs;
  logic [31:0]  exp_d;
  logic [31:0]  exp_g;

  hs_rr_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (DW),
    .BURST_LEN(BL)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_src  (m_src),
    .m_ready(m_ready),
    .grant  (grant)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [DW-1:0] fdat(int k, int j);
    return DW'((k * 3 + j * 5 + 1) % 8);
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(int k);
    sb.push_back((k << 3) | int'(fdat(k, exp_seq[k])));
    exp_seq[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_valid[k] = (rem[k] != 0);
      s_data[k*DW +: DW] = fdat(k, seq[k]);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    hs = s_valid & s_ready;
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        rem[k]--;
        seq[k]++;
      end
    end
    drive();
  endtask

  always @(negedge sys_clk) begin
    if (!rst && m_valid && m_ready) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra got src=%0d data=%0d exp=none",
               m_src, m_data);
      end
      if (sb.size() != 0)
        chk("sb_beat", 32'({m_src, m_data}),
            32'(sb.pop_front()));
    end
  end

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      rem[k]     = 2;
      seq[k]     = 0;
      exp_seq[k] = 0;
    end
    drive();
    step();
    step();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_src", 32'(m_src), 0);
    chk("rst_m_data", 32'(m_data), 0);

    // all four valid: rotation order, wrap 3 -> 0
`ifdef HS_ARB_BURST_LOCK_EN
    push(0); push(0); push(1); push(1);
    push(2); push(2); push(3); push(3);
`else
    push(0); push(1); push(2); push(3);
    push(0); push(1); push(2); push(3);
`endif
    rst = 1'b0;
    step();
    chk("t1_grant", 32'(grant), 1);
    step();
    chk("t1_m_valid", 32'(m_valid), 1);
    chk("t1_m_src", 32'(m_src), 0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t3_gapless", 32'(m_valid), 1);
    end
    step();
    step();
    chk("t3_idle_grant", 32'(grant), 0);
    chk("t3_idle_m_valid", 32'(m_valid), 0);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // single beat from requester 2
    exp_d  = 32'(fdat(2, exp_seq[2]));
    rem[2] = 1;
    push(2);
    drive();
    step();
    chk("t2_grant", 32'(grant), 4);
    chk("t2_s_ready", 32'(s_ready), 4);
    step();
    chk("t2_m_valid", 32'(m_valid), 1);
    chk("t2_m_src", 32'(m_src), 2);
    chk("t2_m_data", 32'(m_data), exp_d);
    step();
    chk("t2_idle_grant", 32'(grant), 0);
    chk("t2_idle_m_valid", 32'(m_valid), 0);

    // backpressure
    exp_d  = 32'(fdat(1, exp_seq[1]));
    rem[1] = 2;
    rem[2] = 2;
`ifdef HS_ARB_BURST_LOCK_EN
    push(1); push(1); push(2); push(2);
    exp_g = 32'h2;
`else
    push(1); push(2); push(1); push(2);
    exp_g = 32'h4;
`endif
    drive();
    step();
    chk("t5_grant", 32'(grant), 2);
    step();
    m_ready = 1'b0;
    #1;
    chk("t5_stall_s_ready", 32'(s_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_m_valid", 32'(m_valid), 1);
      chk("t5_m_src", 32'(m_src), 1);
      chk("t5_m_data", 32'(m_data), exp_d);
      chk("t5_s_ready", 32'(s_ready), 0);
      chk("t5_grant_hold", 32'(grant), exp_g);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t5_sb_empty", 32'(sb.size()), 0);
    chk("t5_m_valid_end", 32'(m_valid), 0);

    // withdrawal of requester 1 while output is full
    m_ready = 1'b0;
    rem[0]  = 1;
    push(0);
    drive();
    step();
    chk("t6_grant0", 32'(grant), 1);
    step();
    rem[1] = 1;
    rem[3] = 1;
    push(3);
    drive();
    step();
    chk("t6_grant1", 32'(grant), 2);
    chk("t6_s_ready", 32'(s_ready), 0);
    chk("t6_m_src", 32'(m_src), 0);
    rem[1] = 0;
    drive();
    step();
    chk("t6_grant3", 32'(grant), 8);
    chk("t6_m_valid", 32'(m_valid), 1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t6_sb_empty", 32'(sb.size()), 0);
    chk("t6_idle_grant", 32'(grant), 0);

    // reset with a beat held in the output stage
    m_ready = 1'b0;
    rem[0]  = 3;
    drive();
    step();
    step();
    chk("t7_m_valid", 32'(m_valid), 1);
    rst = 1'b1;
    step();
    for (int k = 0; k < N; k++) rem[k] = 0;
    drive();
    chk("t7_rst_m_valid", 32'(m_valid), 0);
    chk("t7_rst_grant", 32'(grant), 0);
    chk("t7_rst_m_data", 32'(m_data), 0);
    chk("t7_rst_m_src", 32'(m_src), 0);
    chk("t7_rst_s_ready", 32'(s_ready), 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    step();
    chk("t7_post_grant", 32'(grant), 0);
    chk("t7_post_m_valid", 32'(m_valid), 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
